// File: rtl/csa_stream_accum.sv
// Streaming multi-lane carry-save accumulator: each beat is compressed into a redundant
// (sum, carry) pair; the last beat triggers a resolve and optional end-around-carry fold.
module csa_stream_accum #(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int GUARD = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_data,
  input  logic [LANES-1:0]         in_keep,
  input  logic                     in_last,
  input  logic                     in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_ovf
);

  localparam int ACC_W = WIDTH + GUARD;

  typedef enum logic [1:0] {ACC, RESOLVE, FOLD, OUT} state_t;

  state_t           state_reg;
  logic [ACC_W-1:0] acc_s_reg;
  logic [ACC_W-1:0] acc_c_reg;
  logic [ACC_W-1:0] r_reg;
  logic             first_reg;
  logic             mode_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             out_ovf_reg;

  // chain_c holds carries already shifted to their true weight
  logic [ACC_W-1:0] chain_s [LANES+1];
  logic [ACC_W-1:0] chain_c [LANES];
  logic [ACC_W-1:0] cout_last;
  logic [ACC_W-1:0] cpa_sum;
  logic [ACC_W-1:0] fold_sum;
  logic             hi_nz;

  assign chain_s[0] = first_reg ? '0 : acc_s_reg;
  assign chain_c[0] = first_reg ? '0 : acc_c_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_csa
      logic [ACC_W-1:0] lane_word;
      logic [ACC_W-1:0] carry;
      assign lane_word = in_keep[gi] ? {{GUARD{1'b0}}, in_data[gi*WIDTH +: WIDTH]} : '0;
      assign chain_s[gi+1] = chain_s[gi] ^ chain_c[gi] ^ lane_word;
      assign carry = (chain_s[gi] & chain_c[gi]) | (chain_s[gi] & lane_word)
                   | (chain_c[gi] & lane_word);
      if (gi < LANES - 1) begin : g_mid
        assign chain_c[gi+1] = carry << 1;
      end else begin : g_last
        assign cout_last = carry;
      end
    end
  endgenerate

  assign cpa_sum  = acc_s_reg + acc_c_reg;
  assign fold_sum = {{GUARD{1'b0}}, r_reg[WIDTH-1:0]} + {{WIDTH{1'b0}}, r_reg[ACC_W-1:WIDTH]};
  assign hi_nz    = |r_reg[ACC_W-1:WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ACC;
      acc_s_reg     <= '0;
      acc_c_reg     <= '0;
      r_reg         <= '0;
      first_reg     <= 1'b1;
      mode_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ACC: begin
          if (in_valid && in_ready_reg) begin
            acc_s_reg <= chain_s[LANES];
            acc_c_reg <= cout_last << 1;
            first_reg <= 1'b0;
            if (first_reg) mode_reg <= in_mode;
            if (in_last) begin
              state_reg    <= RESOLVE;
              in_ready_reg <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          r_reg <= cpa_sum;
          if (!mode_reg) begin
            state_reg     <= OUT;
            out_valid_reg <= 1'b1;
            out_ovf_reg   <= |cpa_sum[ACC_W-1:WIDTH];
          end else begin
            state_reg <= FOLD;
          end
        end
        FOLD: begin
          // fold the upper bits back in until nothing remains above WIDTH
          if (hi_nz) begin
            r_reg <= fold_sum;
          end else begin
            state_reg     <= OUT;
            out_valid_reg <= 1'b1;
            out_ovf_reg   <= 1'b0;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_reg     <= ACC;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            first_reg     <= 1'b1;
            acc_s_reg     <= '0;
            acc_c_reg     <= '0;
          end
        end
        default: state_reg <= ACC;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = r_reg[WIDTH-1:0];
  assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_csa_stream_accum.sv
// Scoreboard bench for csa_stream_accum: packets are modelled when driven and
// checked (data, overflow, latency, handshake) when the result appears.
module tb_csa_stream_accum;
  localparam int WIDTH = 32;
  localparam int LANES = 4;
  localparam int GUARD = 16;
  localparam int ACC_W = WIDTH + GUARD;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic [LANES-1:0]       in_keep;
  logic                   in_last;
  logic                   in_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_ovf;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             ovf;
    int               lat;
  } exp_t;

  exp_t                   sb[$];
  logic [LANES*WIDTH-1:0] pkt_data[$];
  logic [LANES-1:0]       pkt_keep[$];
  int                     cyc = 0;
  int                     last_acc_cyc = 0;
  int                     errors = 0;
  int                     checks = 0;

  csa_stream_accum #(.WIDTH(WIDTH), .LANES(LANES), .GUARD(GUARD)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep),
    .in_last(in_last), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [LANES*WIDTH-1:0] beat4(input logic [31:0] l3, input logic [31:0] l2,
                                                   input logic [31:0] l1, input logic [31:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic add_beat(input logic [LANES*WIDTH-1:0] d, input logic [LANES-1:0] k);
    pkt_data.push_back(d);
    pkt_keep.push_back(k);
  endtask

  // Drives the queued beats; later beats carry the inverted mode, which must be ignored.
  task automatic send_packet(input logic mode, input bit with_last, input bit push);
    logic [63:0]            sum;
    logic [LANES*WIDTH-1:0] bw;
    exp_t                   e;
    int                     n;
    int                     k;
    int                     w;
    sum = '0;
    n = pkt_data.size();
    for (int b = 0; b < n; b++) begin
      bw = pkt_data[b];
      for (int l = 0; l < LANES; l++)
        if (pkt_keep[b][l]) sum = sum + 64'(bw[l*WIDTH +: WIDTH]);
    end
    sum = sum & ((64'd1 << ACC_W) - 64'd1);
    if (mode == 1'b0) begin
      e.data = sum[WIDTH-1:0];
      e.ovf  = (sum >> WIDTH) != 0;
      e.lat  = 2;
    end else begin
      k = 0;
      while ((sum >> WIDTH) != 0) begin
        sum = (sum & ((64'd1 << WIDTH) - 64'd1)) + (sum >> WIDTH);
        k++;
      end
      e.data = sum[WIDTH-1:0];
      e.ovf  = 1'b0;
      e.lat  = 3 + k;
    end
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = pkt_data[b];
      in_keep  = pkt_keep[b];
      in_last  = with_last && (b == n - 1);
      in_mode  = (b == 0) ? mode : ~mode;
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
        in_valid = 1'b0;
        pkt_data.delete();
        pkt_keep.delete();
        return;
      end
      @(posedge clk);
      #1;
      last_acc_cyc = cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    pkt_data.delete();
    pkt_keep.delete();
    if (with_last && push) sb.push_back(e);
  endtask

  // Waits for a result, compares with the scoreboard, optionally stalls, then consumes it.
  task automatic collect(input string name, input int hold);
    exp_t e;
    int   w;
    int   lat;
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL %s_valid: out_valid=%b required 1 (pending=%0d)", name, out_valid, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    lat = cyc - last_acc_cyc + 1;
    $display("pkt %s: out_data=%h out_ovf=%b latency=%0d", name, out_data, out_ovf, lat);
    checks++;
    if (out_data !== e.data) begin
      errors++;
      $display("FAIL %s_data: got %h required %h", name, out_data, e.data);
    end
    checks++;
    if (out_ovf !== e.ovf) begin
      errors++;
      $display("FAIL %s_ovf: got %b required %b", name, out_ovf, e.ovf);
    end
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, e.lat);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== e.data || out_ovf !== e.ovf || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_hold%0d: valid=%b data=%h ovf=%b in_ready=%b required 1 %h %b 0",
                 name, h, out_valid, out_data, out_ovf, in_ready, e.data, e.ovf);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: in_ready=%b out_valid=%b required 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_keep   = '0;
    in_last   = 1'b0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h out_ovf=%b required 1 0 0 0",
               in_ready, out_valid, out_data, out_ovf);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_sum_mode0;
    add_beat(beat4(4, 3, 2, 1), 4'hF);
    send_packet(1'b0, 1'b1, 1'b1);
    collect("t1_sum", 0);
    add_beat(beat4(40, 30, 20, 10), 4'b0101);
    send_packet(1'b0, 1'b1, 1'b1);
    collect("t3_keep", 0);
    for (int b = 0; b < 3; b++) add_beat(beat4(1, 1, 1, 1), 4'hF);
    send_packet(1'b0, 1'b1, 1'b1);
    collect("t3_multibeat", 0);
    add_beat(beat4(7, 7, 7, 7), 4'h0);
    add_beat(beat4(9, 9, 9, 9), 4'h1);
    send_packet(1'b0, 1'b1, 1'b1);
    collect("keep_zero_beat", 0);
  endtask

  task automatic test_overflow;
    add_beat(beat4(0, 0, 32'h8000_0000, 32'h8000_0000), 4'b0011);
    send_packet(1'b0, 1'b1, 1'b1);
    collect("t4_ovf", 0);
  endtask

  task automatic test_ones_complement;
    add_beat(beat4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 4'hF);
    send_packet(1'b1, 1'b1, 1'b1);
    collect("t2_fold1", 0);
    add_beat(beat4(0, 0, 2, 1), 4'hF);
    send_packet(1'b1, 1'b1, 1'b1);
    collect("fold0", 0);
    add_beat(beat4(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 4'hF);
    send_packet(1'b1, 1'b1, 1'b1);
    collect("fold2", 0);
  endtask

  task automatic test_backpressure;
    add_beat(beat4(5, 6, 7, 8), 4'hF);
    add_beat(beat4(32'h1234_5678, 0, 0, 1), 4'b1001);
    send_packet(1'b0, 1'b1, 1'b1);
    collect("t5_hold", 5);
    add_beat(beat4(2, 2, 2, 2), 4'hF);
    send_packet(1'b0, 1'b1, 1'b1);
    collect("t5_after", 0);
  endtask

  task automatic test_reset_midpacket;
    for (int b = 0; b < 2; b++) add_beat(beat4(100, 100, 100, 100), 4'hF);
    send_packet(1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL t6_reset_mid: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    add_beat(beat4(1, 1, 1, 1), 4'hF);
    send_packet(1'b0, 1'b1, 1'b1);
    collect("t6_clean", 0);
    add_beat(beat4(3, 3, 3, 3), 4'hF);
    send_packet(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_out_pre: out_valid=%b required 1", out_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_out: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    int nb;
    logic m;
    for (int p = 0; p < 8; p++) begin
      nb = $urandom_range(1, 4);
      m = 1'($urandom_range(0, 1));
      for (int b = 0; b < nb; b++)
        add_beat(beat4($urandom, $urandom, $urandom, $urandom), 4'($urandom_range(0, 15)));
      send_packet(m, 1'b1, 1'b1);
      collect("random", 0);
    end
  endtask

  initial begin
    test_reset();
    test_sum_mode0();
    test_overflow();
    test_ones_complement();
    test_backpressure();
    test_reset_midpacket();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
